// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types: requester owner, FSM state, default widths.
// Imported by the arbiter, its winner-select and its bus interface.
package mem_arb_pkg;

    localparam int ADDR_W_D  = 64;
    localparam int DATA_W_D  = 64;
    localparam int INSTR_W_D = 32;
    localparam int MEM_LAT_D = 1;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around mem_port_arbiter: I and D request/response channels,
// the memory port and busy. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int INSTR_W = INSTR_W_D
) ();

    logic                i_req_valid;
    logic [ADDR_W-1:0]   i_req_addr;
    logic                i_req_ready;
    logic                i_resp_valid;
    logic [INSTR_W-1:0]  i_resp_rdata;

    logic                d_req_valid;
    logic                d_req_we;
    logic [ADDR_W-1:0]   d_req_addr;
    logic [DATA_W-1:0]   d_req_wdata;
    logic [DATA_W/8-1:0] d_req_wstrb;
    logic                d_req_ready;
    logic                d_resp_valid;
    logic [DATA_W-1:0]   d_resp_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_rdata;

    logic                busy;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_rdata,
        input  d_req_valid, d_req_we, d_req_addr,
        input  d_req_wdata, d_req_wstrb,
        output d_req_ready, d_resp_valid, d_resp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_rdata,
        output d_req_valid, d_req_we, d_req_addr,
        output d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_resp_valid, d_resp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select between fetch (I) and load/store (D) requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_valid,
    input  logic   d_valid,
    input  owner_t last_owner,
    output logic   grant_i,
    output logic   grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Alternate on ties; a lone requester always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_valid && d_valid) begin
            grant_i = (last_owner == OWN_DATA);
            grant_d = (last_owner == OWN_INSTR);
        end else begin
            grant_i = i_valid;
            grant_d = d_valid;
        end
    end
`else
    // Data wins ties: it belongs to the instruction already in flight.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        grant_d = d_valid;
        grant_i = i_valid && !d_valid;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I and D requesters onto one single-port memory, one access
// at a time. Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int INSTR_W = INSTR_W_D,
    parameter int MEM_LAT = MEM_LAT_D
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);

    localparam int          SW     = DATA_W / 8;
    localparam logic [3:0]  LAT_M1 = 4'(MEM_LAT - 1);

    state_t              state_q, state_d;
    owner_t              owner_q, last_owner_q;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SW-1:0]       wstrb_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                grant_i, grant_d;
    logic                load_req, cap;

    mem_arb_pick u_pick (
        .i_valid    (bus.i_req_valid & reset),
        .d_valid    (bus.d_req_valid & reset),
        .last_owner (last_owner_q),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Next state, handshake strobes and memory port drive.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        load_req         = 1'b0;
        cap              = 1'b0;
        bus.i_req_ready  = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.i_resp_valid = 1'b0;
        bus.d_resp_valid = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_wstrb    = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    bus.i_req_ready = grant_i;
                    bus.d_req_ready = grant_d;
                    load_req        = 1'b1;
                    state_d         = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (owner_q == OWN_DATA && we_q)
                    bus.mem_wstrb = wstrb_q;
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    cap     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                bus.i_resp_valid = (owner_q == OWN_INSTR);
                bus.d_resp_valid = (owner_q == OWN_DATA);
                state_d          = IDLE;
            end
        endcase
    end

    // State, latched request and held response word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INSTR;
            last_owner_q <= OWN_INSTR;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                owner_q      <= grant_d ? OWN_DATA : OWN_INSTR;
                last_owner_q <= grant_d ? OWN_DATA : OWN_INSTR;
                addr_q       <= grant_d ? bus.d_req_addr : bus.i_req_addr;
                we_q         <= grant_d & bus.d_req_we;
                wdata_q      <= grant_d ? bus.d_req_wdata : '0;
                wstrb_q      <= grant_d ? bus.d_req_wstrb : '0;
            end
            if (cap)
                rdata_q <= (owner_q == OWN_DATA && we_q) ? '0 : bus.mem_rdata;
        end
    end

    assign bus.i_resp_rdata = rdata_q[INSTR_W-1:0];
    assign bus.d_resp_rdata = rdata_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3)
// on a shared byte-strobed memory model, responses checked from queues.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    exp_t iq1[$];
    exp_t dq1[$];
    exp_t iq3[$];
    exp_t dq3[$];

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW)) b3 ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .MEM_LAT(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .MEM_LAT(3)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    logic [63:0]      mem [256];
    logic [63:0]      p1;
    logic [2:0][63:0] p3;

    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3[2];

    // Memory model: zero-filled with one instruction word at 0x40.
    always @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < 256; j++)
                mem[j] <= (j == 8) ? 64'hDEAD_BEEF_0010_0093 : 64'd0;
            p1 <= '0;
            p3 <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (b1.mem_en && b1.mem_we && b1.mem_wstrb[k])
                    mem[b1.mem_addr[10:3]][8*k +: 8] <= b1.mem_wdata[8*k +: 8];
                if (b3.mem_en && b3.mem_we && b3.mem_wstrb[k])
                    mem[b3.mem_addr[10:3]][8*k +: 8] <= b3.mem_wdata[8*k +: 8];
            end
            p1 <= (b1.mem_en && !b1.mem_we) ? mem[b1.mem_addr[10:3]] : 64'd0;
            p3[0] <= (b3.mem_en && !b3.mem_we) ? mem[b3.mem_addr[10:3]] : 64'd0;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end

    function automatic bit d_wins(input bit iv, input bit dv, input owner_t lo);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (iv && dv) return (lo == OWN_INSTR);
`else
        if (iv && dv) return (lo == lo);
`endif
        return dv;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to next negedge and score any response pulses.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (b1.i_resp_valid) begin
            chk("i1_pend", 64'(iq1.size() > 0), 64'd1);
            if (iq1.size() > 0) begin
                e = iq1.pop_front();
                chk("i1_data", 64'(b1.i_resp_rdata), e.d);
                chk("i1_cyc", 64'(cyc), 64'(e.c));
            end
        end
        if (b1.d_resp_valid) begin
            chk("d1_pend", 64'(dq1.size() > 0), 64'd1);
            if (dq1.size() > 0) begin
                e = dq1.pop_front();
                chk("d1_data", b1.d_resp_rdata, e.d);
                chk("d1_cyc", 64'(cyc), 64'(e.c));
            end
        end
        if (b3.i_resp_valid) begin
            chk("i3_pend", 64'(iq3.size() > 0), 64'd1);
            if (iq3.size() > 0) begin
                e = iq3.pop_front();
                chk("i3_data", 64'(b3.i_resp_rdata), e.d);
                chk("i3_cyc", 64'(cyc), 64'(e.c));
            end
        end
        if (b3.d_resp_valid) begin
            chk("d3_pend", 64'(dq3.size() > 0), 64'd1);
            if (dq3.size() > 0) begin
                e = dq3.pop_front();
                chk("d3_data", b3.d_resp_rdata, e.d);
                chk("d3_cyc", 64'(cyc), 64'(e.c));
            end
        end
    endtask

    task automatic d1_req(input bit we, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [7:0] ws);
        b1.d_req_valid = 1'b1;
        b1.d_req_we    = we;
        b1.d_req_addr  = addr;
        b1.d_req_wdata = wd;
        b1.d_req_wstrb = ws;
    endtask

    initial begin
        int     t;
        bit     dw;
        owner_t lo1;

        lo1 = OWN_INSTR;
        b1.i_req_valid = 1'b0; b1.i_req_addr = '0;
        b1.d_req_valid = 1'b0; b1.d_req_we = 1'b0; b1.d_req_addr = '0;
        b1.d_req_wdata = '0;   b1.d_req_wstrb = '0;
        b3.i_req_valid = 1'b0; b3.i_req_addr = '0;
        b3.d_req_valid = 1'b0; b3.d_req_we = 1'b0; b3.d_req_addr = '0;
        b3.d_req_wdata = '0;   b3.d_req_wstrb = '0;

        step();
        step();
        chk("rst_busy", 64'(b1.busy), 64'd0);
        chk("rst_en", 64'(b1.mem_en), 64'd0);
        chk("rst_drdata", b1.d_resp_rdata, 64'd0);
        chk("rst_irdata", 64'(b3.i_resp_rdata), 64'd0);
        reset = 1'b1;
        step();

        // I-only fetch at 0x40
        b1.i_req_valid = 1'b1; b1.i_req_addr = 64'h40;
        #1;
        chk("t1_irdy", 64'(b1.i_req_ready), 64'd1);
        chk("t1_drdy", 64'(b1.d_req_ready), 64'd0);
        iq1.push_back('{d: 64'h0010_0093, c: cyc + 3});
        lo1 = OWN_INSTR;
        step();
        b1.i_req_valid = 1'b0;
        chk("t1_en", 64'(b1.mem_en), 64'd1);
        chk("t1_addr", b1.mem_addr, 64'h40);
        chk("t1_we", 64'(b1.mem_we), 64'd0);
        chk("t1_busy", 64'(b1.busy), 64'd1);
        repeat (3) step();

        // D store 0x100, low four bytes only
        d1_req(1'b1, 64'h100, 64'h1122_3344_5566_7788, 8'h0F);
        #1;
        chk("t2_drdy", 64'(b1.d_req_ready), 64'd1);
        dq1.push_back('{d: 64'd0, c: cyc + 3});
        lo1 = OWN_DATA;
        step();
        b1.d_req_valid = 1'b0;
        chk("t2_en", 64'(b1.mem_en), 64'd1);
        chk("t2_we", 64'(b1.mem_we), 64'd1);
        chk("t2_wstrb", 64'(b1.mem_wstrb), 64'h0F);
        chk("t2_wdata", b1.mem_wdata, 64'h1122_3344_5566_7788);
        repeat (3) step();

        // D load back 0x100
        d1_req(1'b0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        #1;
        chk("t2l_drdy", 64'(b1.d_req_ready), 64'd1);
        dq1.push_back('{d: 64'h0000_0000_5566_7788, c: cyc + 3});
        step();
        b1.d_req_valid = 1'b0;
        chk("t2l_we", 64'(b1.mem_we), 64'd0);
        chk("t2l_wstrb", 64'(b1.mem_wstrb), 64'd0);
        repeat (3) step();

        // D load of full word at 0x40
        d1_req(1'b0, 64'h40, 64'd0, 8'd0);
        #1;
        dq1.push_back('{d: 64'hDEAD_BEEF_0010_0093, c: cyc + 3});
        step();
        b1.d_req_valid = 1'b0;
        repeat (3) step();

        // Simultaneous I and D
        b1.i_req_valid = 1'b1; b1.i_req_addr = 64'h40;
        d1_req(1'b0, 64'h100, 64'd0, 8'd0);
        #1;
        t  = cyc;
        dw = d_wins(1'b1, 1'b1, lo1);
        chk("t3_irdy", 64'(b1.i_req_ready), 64'(!dw));
        chk("t3_drdy", 64'(b1.d_req_ready), 64'(dw));
        if (dw) begin
            dq1.push_back('{d: 64'h5566_7788, c: t + 3});
            iq1.push_back('{d: 64'h0010_0093, c: t + 7});
        end else begin
            iq1.push_back('{d: 64'h0010_0093, c: t + 3});
            dq1.push_back('{d: 64'h5566_7788, c: t + 7});
        end
        step();
        if (dw) b1.d_req_valid = 1'b0;
        else    b1.i_req_valid = 1'b0;
        #1;
        chk("t3_no_rdy", 64'({b1.i_req_ready, b1.d_req_ready}), 64'd0);
        repeat (3) step();
        #1;
        chk("t3_loser_rdy", 64'(dw ? b1.i_req_ready : b1.d_req_ready), 64'd1);
        step();
        b1.i_req_valid = 1'b0;
        b1.d_req_valid = 1'b0;
        repeat (4) step();

        // MEM_LAT=3 load; I request arriving in WAIT waits for IDLE
        b3.d_req_valid = 1'b1; b3.d_req_we = 1'b0; b3.d_req_addr = 64'h40;
        #1;
        t = cyc;
        chk("t4_drdy", 64'(b3.d_req_ready), 64'd1);
        dq3.push_back('{d: 64'hDEAD_BEEF_0010_0093, c: t + 5});
        step();
        b3.d_req_valid = 1'b0;
        chk("t4_en", 64'(b3.mem_en), 64'd1);
        chk("t4_busy1", 64'(b3.busy), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            step();
            if (k == 2) b3.i_req_valid = 1'b1;
            b3.i_req_addr = 64'h40;
            #1;
            chk("t4_en_off", 64'(b3.mem_en), 64'd0);
            chk("t4_busy", 64'(b3.busy), 64'd1);
            chk("t4_irdy_held", 64'(b3.i_req_ready), 64'd0);
        end
        step();
        #1;
        chk("t4_idle", 64'(b3.busy), 64'd0);
        chk("t4_irdy", 64'(b3.i_req_ready), 64'd1);
        iq3.push_back('{d: 64'h0010_0093, c: t + 11});
        step();
        b3.i_req_valid = 1'b0;
        repeat (5) step();

        // Reset during WAIT drops the access
        b3.d_req_valid = 1'b1; b3.d_req_we = 1'b0; b3.d_req_addr = 64'h40;
        step();
        b3.d_req_valid = 1'b0;
        step();
        chk("t5_wait_busy", 64'(b3.busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_busy", 64'(b3.busy), 64'd0);
        chk("t5_en", 64'(b3.mem_en), 64'd0);
        chk("t5_drdata", b3.d_resp_rdata, 64'd0);
        chk("t5_irdata", 64'(b3.i_resp_rdata), 64'd0);
        step();
        reset = 1'b1;
        repeat (8) step();
        b3.i_req_valid = 1'b1; b3.i_req_addr = 64'h40;
        #1;
        chk("t5_irdy", 64'(b3.i_req_ready), 64'd1);
        iq3.push_back('{d: 64'h0010_0093, c: cyc + 5});
        step();
        b3.i_req_valid = 1'b0;
        repeat (6) step();

        chk("drain_i1", 64'(iq1.size()), 64'd0);
        chk("drain_d1", 64'(dq1.size()), 64'd0);
        chk("drain_i3", 64'(iq3.size()), 64'd0);
        chk("drain_d3", 64'(dq3.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the multicycle core.
- Sits between the control/processing datapath and the memory model.
- Serialises accesses: at most one transaction outstanding.
- Hides memory read latency behind a valid/ready request and one-cycle response-pulse handshake.

Parameters:
- ADDR_W, 64, byte address width
- DATA_W, 64, memory data width; D port width
- INSTR_W, 32, I port response width (low bits of memory word)
- MEM_LAT, 1, memory read latency in cycles after the enable cycle; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- i_req_valid  in  1  fetch request
- i_req_addr  in  ADDR_W  fetch address
- i_req_ready  out  1  fetch request accepted (grant) this cycle
- i_resp_valid  out  1  one-cycle pulse, fetch data valid
- i_resp_rdata  out  INSTR_W  fetched instruction
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  store byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  one-cycle pulse, load data / store ack
- d_resp_rdata  out  DATA_W  load data (0 on store ack)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_owner=OWN_INSTR, wait counter=0.
  - All outputs 0, including registered response data.
  - A transaction in flight is dropped; no response is issued for it.
- Requesters must hold valid, addr, we, wdata and wstrb stable until ready. ready is combinational in IDLE only and is never asserted outside IDLE.
- States:
  - IDLE:
    - If any valid, pick a winner and assert its ready.
    - Latch the winner's addr/we/wdata/wstrb and owner.
    - Go to ACCESS. With no valid, stay in IDLE.
  - ACCESS:
    - mem_en=1; mem_we, mem_addr, mem_wdata and mem_wstrb come from the latched request (mem_wstrb forced to 0 for the I owner and for loads).
    - Load the wait counter with MEM_LAT-1; go to WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - When the counter equals 0, capture mem_rdata into the response register and go to RESP.
  - RESP:
    - Assert the owner's resp_valid for exactly one cycle.
    - I gets mem_rdata[INSTR_W-1:0]; D gets the full word, or 0 for a store.
    - Go to IDLE.
- Latency: grant in cycle T; mem_en in T+1; resp_valid in T+2+MEM_LAT.
- Back-to-back minimum: one transaction per 3+MEM_LAT cycles.
- Arbitration (default): fixed priority, D over I.
  - Rationale: a pending data access always belongs to the instruction already in flight.
- Simultaneous I and D valid in IDLE: only the winner sees ready. The loser keeps valid asserted and is granted on the next IDLE.
- A request arriving in ACCESS, WAIT or RESP is not seen until IDLE.
- A stores' response pulse acts as a write acknowledge; the store is complete at the ACCESS edge.
- Response data register is held between pulses; resp_valid is the only qualifier.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- When defined:
  - Arbitration is round-robin on ties: the requester not recorded in last_owner wins.
  - last_owner updates at each grant.
  - A single valid requester always wins.
- When undefined:
  - Fixed D-over-I priority.
  - last_owner is still registered but unused by the pick.

Decomposition:
- Package mem_arb_pkg:
  - owner_t {OWN_INSTR, OWN_DATA}
  - arbiter state_t {IDLE, ACCESS, WAIT, RESP}
  - default width localparams
- Sub-module mem_arb_pick: combinational winner select from (i_valid, d_valid, last_owner). It holds the only `ifdef MEM_ARB_ROUND_ROBIN_EN.

Test Plan:
- I-only fetch at addr 0x40 with mem word 0xDEADBEEF_00100093, MEM_LAT=1 -> i_req_ready at T; mem_en at T+1 with addr 0x40; i_resp_valid at T+3 with rdata 0x00100093; d_resp_valid never asserted.
- D store addr 0x100, wdata 0x1122334455667788, wstrb 0x0F -> mem_we=1 with wstrb 0x0F at T+1; d_resp_valid at T+3 with rdata 0; a following D load of 0x100 returns 0x0000000055667788 from a zero-initialised memory.
- I and D valid in the same cycle, fixed priority -> D granted first, I granted at the next IDLE; two pulses 4 cycles apart, D first. With MEM_ARB_ROUND_ROBIN_EN and last_owner=OWN_DATA -> I granted first.
- MEM_LAT=3 load -> mem_en at T+1, d_resp_valid at T+5, busy high over T+1..T+5, exactly one pulse.
- Reset asserted during WAIT -> all outputs 0 immediately, no resp_valid after release; a new I request after release completes normally.
